pc_trans: RTL and testbench

//  Next-PC generator for the pipelined MIPS fetch unit. Combinationally selects the

---
 rtl/pc_trans.sv | 92 +++++++++
 tb/tb_pc_trans.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pc_trans.sv
// Next-PC generator for the pipelined MIPS fetch unit.
// All PC values are offsets from TEXT_BASE; physical-address inputs (jr_PC,
// EPCOut) and the exception entry are rebased by subtracting TEXT_BASE.
// redir_q flags that the previous cycle chose a non-sequential fetch address.
module pc_trans #(
    parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic [2:0]  nPC_sel,
    input  logic [15:0] sel_PC,
    input  logic [31:0] jr_PC,
    input  logic [25:0] instr_index,
    input  logic        Req,
    input  logic [31:0] EPCOut,
    input  logic        ID_EXLClr,
    output logic [31:0] next_PC,
    output logic        redir_q
);

    typedef enum logic [2:0] {
        NPC_SEQ    = 3'd0,
        NPC_BRANCH = 3'd1,
        NPC_JUMP   = 3'd2,
        NPC_JR     = 3'd3
    } npc_sel_e;

    logic [31:0] seq_pc;
    logic [31:0] br_pc;
    logic [31:0] j_pc;
    logic [31:0] jr_off;
    logic [31:0] epc_off;
    logic [3:0]  pa_hi;
    logic        redir_d;

    // Candidate addresses for every source, all 32-bit modulo arithmetic.
    always_comb begin
        seq_pc  = PC + 32'd4;
        br_pc   = PC + {{14{sel_PC[15]}}, sel_PC, 2'b00};
        // Jump region comes from the physical address of the current PC.
        pa_hi   = 4'((PC + TEXT_BASE) >> 28);
        j_pc    = {pa_hi, instr_index, 2'b00} - TEXT_BASE;
        jr_off  = jr_PC - TEXT_BASE;
        epc_off = EPCOut - TEXT_BASE;
    end

    // Priority select: exception entry, then ERET, then the nPC_sel source.
    always_comb begin
        next_PC = seq_pc;
        redir_d = 1'b0;
        if (Req) begin
            next_PC = EXC_ENTRY - TEXT_BASE;
            redir_d = 1'b1;
        end else if (ID_EXLClr) begin
            next_PC = epc_off;
            redir_d = 1'b1;
        end else begin
            case (npc_sel_e'(nPC_sel))
                NPC_SEQ: begin
                    next_PC = seq_pc;
                end
                NPC_BRANCH: begin
                    next_PC = br_pc;
                    redir_d = 1'b1;
                end
                NPC_JUMP: begin
                    next_PC = j_pc;
                    redir_d = 1'b1;
                end
                NPC_JR: begin
                    next_PC = jr_off;
                    redir_d = 1'b1;
                end
                default: begin
                    next_PC = seq_pc;
                end
            endcase
        end
    end

    // Record whether this cycle redirected fetch; reset clears the flag only.
    always_ff @(posedge clk) begin
        if (reset) begin
            redir_q <= 1'b0;
        end else begin
            redir_q <= redir_d;
        end
    end

endmodule

// File: tb/tb_pc_trans.sv
// Self-checking bench for pc_trans: directed cases followed by random vectors
// checked against an arithmetic reference model of the next-PC rules.
module tb_pc_trans;

    logic        clk;
    logic        reset;
    logic [31:0] PC;
    logic [2:0]  nPC_sel;
    logic [15:0] sel_PC;
    logic [31:0] jr_PC;
    logic [25:0] instr_index;
    logic        Req;
    logic [31:0] EPCOut;
    logic        ID_EXLClr;
    logic [31:0] next_PC;
    logic        redir_q;

    int unsigned vectors;
    int unsigned miscompares;

    pc_trans #(
        .TEXT_BASE(32'h0000_3000),
        .EXC_ENTRY(32'h0000_4180)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .PC         (PC),
        .nPC_sel    (nPC_sel),
        .sel_PC     (sel_PC),
        .jr_PC      (jr_PC),
        .instr_index(instr_index),
        .Req        (Req),
        .EPCOut     (EPCOut),
        .ID_EXLClr  (ID_EXLClr),
        .next_PC    (next_PC),
        .redir_q    (redir_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: next fetch offset from the source rules.
    function automatic logic [31:0] ref_npc(
        input logic [31:0] pc, input logic [2:0] sel, input logic [15:0] imm,
        input logic [31:0] jr, input logic [25:0] idx, input logic req,
        input logic eret, input logic [31:0] epc);
        int          off;
        logic [31:0] pa;
        if (req) return 32'h0000_4180 - 32'h0000_3000;
        if (eret) return epc - 32'h0000_3000;
        case (sel)
            3'd1: begin
                off = int'($signed(imm)) * 4;
                return pc + 32'(off);
            end
            3'd2: begin
                pa = pc + 32'h0000_3000;
                return (pa & 32'hF000_0000) + (32'(idx) * 32'd4) - 32'h0000_3000;
            end
            3'd3: return jr - 32'h0000_3000;
            default: return pc + 32'd4;
        endcase
    endfunction

    function automatic logic ref_redir(input logic rst, input logic [2:0] sel,
                                       input logic req, input logic eret);
        if (rst) return 1'b0;
        return req || eret || (sel >= 3'd1 && sel <= 3'd3);
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one vector, check next_PC combinationally, then redir_q after the edge.
    task automatic step(input string tag, input logic rst, input logic [31:0] pc,
                        input logic [2:0] sel, input logic [15:0] imm,
                        input logic [31:0] jr, input logic [25:0] idx,
                        input logic req, input logic eret, input logic [31:0] epc,
                        input logic [31:0] exp_npc);
        logic exp_r;
        reset = rst; PC = pc; nPC_sel = sel; sel_PC = imm; jr_PC = jr;
        instr_index = idx; Req = req; ID_EXLClr = eret; EPCOut = epc;
        exp_r = ref_redir(rst, sel, req, eret);
        #1;
        chk32({tag, "_npc"}, next_PC, exp_npc);
        @(posedge clk);
        #1;
        chk1({tag, "_redir"}, redir_q, exp_r);
    endtask

    initial begin
        logic [31:0] r_pc, r_jr, r_epc, r_exp;
        logic [2:0]  r_sel;
        logic [15:0] r_imm;
        logic [25:0] r_idx;
        logic        r_req, r_eret, r_rst;

        vectors = 0;
        miscompares = 0;
        reset = 1'b1; PC = '0; nPC_sel = '0; sel_PC = '0; jr_PC = '0;
        instr_index = '0; Req = 1'b0; ID_EXLClr = 1'b0; EPCOut = '0;
        @(posedge clk);
        #1;
        chk1("reset_redir", redir_q, 1'b0);

        step("seq0",     1'b0, 32'h0,     3'd0, 16'h0,    32'h0,    26'h0,   1'b0, 1'b0, 32'h0,    32'h4);
        step("seq_ffc",  1'b0, 32'hFFC,   3'd0, 16'h0,    32'h0,    26'h0,   1'b0, 1'b0, 32'h0,    32'h1000);
        step("br_pos",   1'b0, 32'h10,    3'd1, 16'h0003, 32'h0,    26'h0,   1'b0, 1'b0, 32'h0,    32'h1C);
        step("br_neg",   1'b0, 32'h10,    3'd1, 16'hFFFE, 32'h0,    26'h0,   1'b0, 1'b0, 32'h0,    32'h08);
        step("br_min",   1'b0, 32'h40000, 3'd1, 16'h8000, 32'h0,    26'h0,   1'b0, 1'b0, 32'h0,    32'h20000);
        step("jump",     1'b0, 32'h20,    3'd2, 16'h0,    32'h0,    26'h0C01, 1'b0, 1'b0, 32'h0,   32'h4);
        step("jump_hi",  1'b0, 32'hA000_0000, 3'd2, 16'h0, 32'h0,   26'h0001, 1'b0, 1'b0, 32'h0,   32'hA000_0004 - 32'h3000);
        step("jr",       1'b0, 32'h20,    3'd3, 16'h0,    32'h3040, 26'h0,   1'b0, 1'b0, 32'h0,    32'h40);
        for (int s = 0; s < 8; s++)
            step("req", 1'b0, 32'h55, 3'(s), 16'h1234, 32'h7000, 26'h123, 1'b1, 1'b0, 32'h9000, 32'h1180);
        step("eret",     1'b0, 32'h30,    3'd1, 16'h0010, 32'h0,    26'h0,   1'b0, 1'b1, 32'h3008, 32'h8);
        step("eret_wrap",1'b0, 32'h30,    3'd0, 16'h0,    32'h0,    26'h0,   1'b0, 1'b1, 32'h0,    32'hFFFF_D000);
        step("req_eret", 1'b0, 32'h30,    3'd2, 16'h0,    32'h0,    26'h0,   1'b1, 1'b1, 32'h3008, 32'h1180);
        step("resv5",    1'b0, 32'h100,   3'd5, 16'h0,    32'h0,    26'h0,   1'b0, 1'b0, 32'h0,    32'h104);
        step("pre_rst",  1'b0, 32'h20,    3'd3, 16'h0,    32'h3040, 26'h0,   1'b0, 1'b0, 32'h0,    32'h40);
        step("rst_redir",1'b1, 32'h20,    3'd2, 16'h0,    32'h0,    26'h0C01, 1'b1, 1'b0, 32'h0,   32'h1180);

        for (int i = 0; i < 10000; i++) begin
            r_pc   = $urandom;
            r_sel  = 3'($urandom_range(0, 7));
            r_imm  = 16'($urandom);
            r_jr   = $urandom;
            r_idx  = 26'($urandom);
            r_epc  = $urandom;
            r_req  = ($urandom_range(0, 7) == 0);
            r_eret = ($urandom_range(0, 5) == 0);
            r_rst  = ($urandom_range(0, 31) == 0);
            r_exp  = ref_npc(r_pc, r_sel, r_imm, r_jr, r_idx, r_req, r_eret, r_epc);
            step("rand", r_rst, r_pc, r_sel, r_imm, r_jr, r_idx, r_req, r_eret, r_epc, r_exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
